// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal_sync RF request scheduler.
package fractal_sync_pkg;

    typedef enum logic [2:0] {
        WAIT   = 3'd0,
        SYNC   = 3'd1,
        BYPASS = 3'd2,
        IGNORE = 3'd3,
        ID_ERR = 3'd4
    } rsp_status_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    // Collapse one RF port verdict into a status; id errors dominate everything.
    function automatic rsp_status_e rf_verdict(input logic id_err, input logic ignore,
                                               input logic bypass, input logic present);
        if (id_err)       return ID_ERR;
        else if (ignore)  return IGNORE;
        else if (bypass)  return BYPASS;
        else if (present) return SYNC;
        else              return WAIT;
    endfunction

endpackage

// File: rtl/fractal_sync_rr_multi_grant.sv
// Rotating selector: picks up to N_PORTS pending slots starting at rr_ptr.
// Port k receives the k-th pending slot in scan order.
module fractal_sync_rr_multi_grant #(
    parameter int N_REQ   = 4,
    parameter int N_PORTS = 2,
    parameter int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0]                pend_i,
    input  logic [PTR_W-1:0]                rr_ptr_i,
    output logic [N_PORTS-1:0]              port_valid_o,
    output logic [N_PORTS-1:0][PTR_W-1:0]   port_idx_o,
    output logic [PTR_W-1:0]                rr_ptr_next_o
);

    int scan_off [N_REQ];
    int rank     [N_REQ];
    int best_off;

    // Rank each pending slot by its distance from rr_ptr; rank k goes to port k.
    always_comb begin
        port_valid_o  = '0;
        port_idx_o    = '0;
        rr_ptr_next_o = rr_ptr_i;
        best_off      = -1;
        for (int j = 0; j < N_REQ; j++) begin
            scan_off[j] = (j - int'(rr_ptr_i) + N_REQ) % N_REQ;
            rank[j]     = 0;
        end
        for (int j = 0; j < N_REQ; j++) begin
            for (int m = 0; m < N_REQ; m++) begin
                if (pend_i[m] && (scan_off[m] < scan_off[j])) begin
                    rank[j] = rank[j] + 1;
                end
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (pend_i[j] && (rank[j] < N_PORTS)) begin
                for (int k = 0; k < N_PORTS; k++) begin
                    if (rank[j] == k) begin
                        port_valid_o[k] = 1'b1;
                        port_idx_o[k]   = PTR_W'(j);
                    end
                end
                if (scan_off[j] > best_off) begin
                    best_off      = scan_off[j];
                    rr_ptr_next_o = PTR_W'((j + 1) % N_REQ);
                end
            end
        end
    end

endmodule

// File: rtl/fractal_sync_rf_req_sched.sv
// Request scheduler in front of the 1D local barrier RF: one buffered request
// per requester, up to N_PORTS RF checks per cycle, registered responses.
//
//   state | meaning
//   IDLE  | slot empty, accepting a request
//   PEND  | id buffered, waiting for an RF check port
//   RESP  | status held until the requester takes it
module fractal_sync_rf_req_sched #(
    parameter int N_REQ     = 4,
    parameter int N_PORTS   = 2,
    parameter int ID_WIDTH  = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [N_REQ-1:0]                   req_valid_i,
    output logic [N_REQ-1:0]                   req_ready_o,
    input  logic [N_REQ-1:0][ID_WIDTH-1:0]     req_id_i,
    output logic [N_PORTS-1:0]                 rf_check_o,
    output logic [N_PORTS-1:0][ID_WIDTH-1:0]   rf_id_o,
    input  logic [N_PORTS-1:0]                 rf_present_i,
    input  logic [N_PORTS-1:0]                 rf_id_err_i,
    input  logic [N_PORTS-1:0]                 rf_bypass_i,
    input  logic [N_PORTS-1:0]                 rf_ignore_i,
    output logic [N_REQ-1:0]                   rsp_valid_o,
    input  logic [N_REQ-1:0]                   rsp_ready_i,
    output logic [N_REQ-1:0][2:0]              rsp_status_o,
    output logic [ERR_CNT_W-1:0]               err_cnt_o
);

    import fractal_sync_pkg::*;

    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int NERR_W = $clog2(N_PORTS + 1);
    localparam int SUM_W  = ERR_CNT_W + NERR_W;

    sched_state_e              state_q  [N_REQ];
    sched_state_e              state_d  [N_REQ];
    logic [ID_WIDTH-1:0]       id_q     [N_REQ];
    logic [ID_WIDTH-1:0]       id_d     [N_REQ];
    rsp_status_e               status_q [N_REQ];
    rsp_status_e               status_d [N_REQ];
    logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d, rr_ptr_next;
    logic [ERR_CNT_W-1:0]      err_cnt_q, err_cnt_d;
    logic [NERR_W-1:0]         n_err;
    logic [SUM_W-1:0]          err_sum;

    logic [N_REQ-1:0]               pend;
    logic [N_PORTS-1:0]             port_valid;
    logic [N_PORTS-1:0][PTR_W-1:0]  port_idx;
    rsp_status_e                    port_status [N_PORTS];

    // Pending vector and registered-state handshake outputs.
    always_comb begin
        for (int j = 0; j < N_REQ; j++) begin
            pend[j]         = (state_q[j] == PEND);
            req_ready_o[j]  = (state_q[j] == IDLE);
            rsp_valid_o[j]  = (state_q[j] == RESP);
            rsp_status_o[j] = status_q[j];
        end
    end

    assign err_cnt_o = err_cnt_q;

    fractal_sync_rr_multi_grant #(
        .N_REQ   (N_REQ),
        .N_PORTS (N_PORTS),
        .PTR_W   (PTR_W)
    ) u_grant (
        .pend_i        (pend),
        .rr_ptr_i      (rr_ptr_q),
        .port_valid_o  (port_valid),
        .port_idx_o    (port_idx),
        .rr_ptr_next_o (rr_ptr_next)
    );

    // RF port drive from slot registers only, plus per-port verdict decode.
    always_comb begin
        rf_check_o = port_valid;
        rf_id_o    = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            port_status[k] = rf_verdict(rf_id_err_i[k], rf_ignore_i[k],
                                        rf_bypass_i[k], rf_present_i[k]);
            for (int j = 0; j < N_REQ; j++) begin
                if (port_valid[k] && (port_idx[k] == PTR_W'(j))) begin
                    rf_id_o[k] = id_q[j];
                end
            end
        end
    end

    // Slot FSMs, round-robin pointer and saturating id-error count.
    always_comb begin
        rr_ptr_d = rr_ptr_next;
        n_err    = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (port_valid[k] && rf_id_err_i[k]) begin
                n_err = n_err + NERR_W'(1);
            end
        end
        err_sum   = SUM_W'(err_cnt_q) + SUM_W'(n_err);
        err_cnt_d = (|err_sum[SUM_W-1:ERR_CNT_W]) ? '1 : err_sum[ERR_CNT_W-1:0];

        for (int j = 0; j < N_REQ; j++) begin
            state_d[j]  = state_q[j];
            id_d[j]     = id_q[j];
            status_d[j] = status_q[j];
            case (state_q[j])
                IDLE: begin
                    if (req_valid_i[j]) begin
                        state_d[j] = PEND;
                        id_d[j]    = req_id_i[j];
                    end
                end
                PEND: begin
                    for (int k = 0; k < N_PORTS; k++) begin
                        if (port_valid[k] && (port_idx[k] == PTR_W'(j))) begin
                            state_d[j]  = RESP;
                            status_d[j] = port_status[k];
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready_i[j]) begin
                        state_d[j] = IDLE;
                    end
                end
                default: state_d[j] = IDLE;
            endcase
        end
    end

    // State registers; reset drops any pending or held request silently.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int j = 0; j < N_REQ; j++) begin
                state_q[j]  <= IDLE;
                id_q[j]     <= '0;
                status_q[j] <= WAIT;
            end
            rr_ptr_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            for (int j = 0; j < N_REQ; j++) begin
                state_q[j]  <= state_d[j];
                id_q[j]     <= id_d[j];
                status_q[j] <= status_d[j];
            end
            rr_ptr_q  <= rr_ptr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_fractal_sync_rf_req_sched.sv
// Bench for fractal_sync_rf_req_sched: slot-set reference model checked every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_fractal_sync_rf_req_sched;

    localparam int N   = 4;
    localparam int NP  = 2;
    localparam int IDW = 4;
    localparam int EW  = 8;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic                     clk_i = 1'b0;
    logic                     rst_i = 1'b1;
    logic [N-1:0]             req_valid_i = '0;
    logic [N-1:0]             req_ready_o;
    logic [N-1:0][IDW-1:0]    req_id_i = '0;
    logic [NP-1:0]            rf_check_o;
    logic [NP-1:0][IDW-1:0]   rf_id_o;
    logic [NP-1:0]            rf_present_i = '0;
    logic [NP-1:0]            rf_id_err_i  = '0;
    logic [NP-1:0]            rf_bypass_i  = '0;
    logic [NP-1:0]            rf_ignore_i  = '0;
    logic [N-1:0]             rsp_valid_o;
    logic [N-1:0]             rsp_ready_i = '1;
    logic [N-1:0][2:0]        rsp_status_o;
    logic [EW-1:0]            err_cnt_o;

    int n_pass  = 0;
    int n_total = 0;

    fractal_sync_rf_req_sched #(
        .N_REQ(N), .N_PORTS(NP), .ID_WIDTH(IDW), .ERR_CNT_W(EW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_id_i     (req_id_i),
        .rf_check_o   (rf_check_o),
        .rf_id_o      (rf_id_o),
        .rf_present_i (rf_present_i),
        .rf_id_err_i  (rf_id_err_i),
        .rf_bypass_i  (rf_bypass_i),
        .rf_ignore_i  (rf_ignore_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_status_o (rsp_status_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit m_pend [N];
    bit m_hold [N];
    int m_id   [N];
    int m_stat [N];
    int m_rr   = 0;
    int m_err  = 0;
    int g_slot [NP];
    int g_n;

    function automatic int verdict(bit e, bit ig, bit b, bit p);
        if (e)  return 4;
        if (ig) return 3;
        if (b)  return 2;
        if (p)  return 1;
        return 0;
    endfunction

    // Walk slots from the round-robin pointer and take the first NP waiting ones.
    function automatic void calc_grant();
        int s;
        g_n = 0;
        for (int i = 0; i < NP; i++) g_slot[i] = 0;
        for (int i = 0; i < N; i++) begin
            s = (m_rr + i) % N;
            if (m_pend[s] && g_n < NP) begin
                g_slot[g_n] = s;
                g_n++;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < N; s++) begin
            m_pend[s] = 0; m_hold[s] = 0; m_id[s] = 0; m_stat[s] = 0;
        end
        m_rr  = 0;
        m_err = 0;
    endfunction

    function automatic void model_step();
        bit pend0 [N];
        bit hold0 [N];
        int s;
        calc_grant();
        pend0 = m_pend;
        hold0 = m_hold;
        for (int k = 0; k < g_n; k++) begin
            s = g_slot[k];
            m_pend[s] = 0;
            m_hold[s] = 1;
            m_stat[s] = verdict(rf_id_err_i[k], rf_ignore_i[k], rf_bypass_i[k], rf_present_i[k]);
            if (rf_id_err_i[k] && m_err < ERR_MAX) m_err++;
        end
        if (g_n > 0) m_rr = (g_slot[g_n-1] + 1) % N;
        for (int j = 0; j < N; j++) begin
            if (hold0[j] && rsp_ready_i[j]) m_hold[j] = 0;
            if (!pend0[j] && !hold0[j] && req_valid_i[j]) begin
                m_pend[j] = 1;
                m_id[j]   = int'(req_id_i[j]);
            end
        end
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) model_reset();
        else       model_step();
    end

    // Every-cycle comparison of all outputs against the model.
    logic [N-1:0]  e_ready, e_valid;
    logic [NP-1:0] e_chk;
    int            e_id;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            calc_grant();
            for (int s = 0; s < N; s++) begin
                e_ready[s] = !m_pend[s] && !m_hold[s];
                e_valid[s] = m_hold[s];
                check($sformatf("rsp_status[%0d]", s), 32'(rsp_status_o[s]), 32'(m_stat[s]));
            end
            for (int k = 0; k < NP; k++) begin
                e_chk[k] = (k < g_n);
                e_id     = (k < g_n) ? m_id[g_slot[k]] : 0;
                check($sformatf("rf_id[%0d]", k), 32'(rf_id_o[k]), 32'(e_id));
            end
            check("req_ready", 32'(req_ready_o), 32'(e_ready));
            check("rsp_valid", 32'(rsp_valid_o), 32'(e_valid));
            check("rf_check",  32'(rf_check_o),  32'(e_chk));
            check("err_cnt",   32'(err_cnt_o),   32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic clr_rf();
        rf_present_i = '0; rf_id_err_i = '0; rf_bypass_i = '0; rf_ignore_i = '0;
    endtask

    // Present requests, drive the RF verdict during the check cycle, let responses drain.
    task automatic batch(input logic [N-1:0] mask, input logic [IDW-1:0] id,
                         input logic [NP-1:0] err, input logic [NP-1:0] ign,
                         input logic [NP-1:0] byp, input logic [NP-1:0] pres);
        @(negedge clk_i);
        req_valid_i = mask;
        for (int s = 0; s < N; s++) req_id_i[s] = id;
        @(negedge clk_i);
        req_valid_i  = '0;
        rf_id_err_i  = err;
        rf_ignore_i  = ign;
        rf_bypass_i  = byp;
        rf_present_i = pres;
        @(negedge clk_i);
        clr_rf();
        @(negedge clk_i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_req_ready", 32'(req_ready_o), 32'h0000_000f);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
        check("rst_rf_check",  32'(rf_check_o),  32'h0);
        check("rst_err_cnt",   32'(err_cnt_o),   32'h0);
        check("rst_status0",   32'(rsp_status_o[0]), 32'h0);

        // Contention: all four at once from rr_ptr = 0
        @(negedge clk_i);
        req_valid_i = 4'hf;
        for (int s = 0; s < N; s++) req_id_i[s] = IDW'(s + 1);
        @(negedge clk_i);
        req_valid_i = '0;
        check("cont_c1_check", 32'(rf_check_o), 32'h3);
        check("cont_c1_id0",   32'(rf_id_o[0]), 32'h1);
        check("cont_c1_id1",   32'(rf_id_o[1]), 32'h2);
        @(negedge clk_i);
        check("cont_c2_check", 32'(rf_check_o), 32'h3);
        check("cont_c2_id0",   32'(rf_id_o[0]), 32'h3);
        check("cont_c2_id1",   32'(rf_id_o[1]), 32'h4);
        check("cont_c2_valid", 32'(rsp_valid_o), 32'h3);
        @(negedge clk_i);
        check("cont_c3_valid", 32'(rsp_valid_o), 32'hc);
        @(negedge clk_i);
        check("cont_idle", 32'(req_ready_o), 32'hf);
        // rr_ptr back at 0: slot 1 must land on port 0 ahead of slot 3
        @(negedge clk_i);
        req_valid_i = 4'b1010;
        req_id_i[1] = 4'h9;
        req_id_i[3] = 4'hb;
        @(negedge clk_i);
        req_valid_i = '0;
        check("rr0_id0", 32'(rf_id_o[0]), 32'h9);
        check("rr0_id1", 32'(rf_id_o[1]), 32'hb);
        repeat (2) @(negedge clk_i);

        // Single request, RF reports not present
        @(negedge clk_i);
        req_valid_i = 4'b0001;
        req_id_i[0] = 4'h2;
        @(negedge clk_i);
        req_valid_i = '0;
        check("single_check", 32'(rf_check_o), 32'h1);
        check("single_id",    32'(rf_id_o[0]), 32'h2);
        @(negedge clk_i);
        check("single_valid",  32'(rsp_valid_o), 32'h1);
        check("single_status", 32'(rsp_status_o[0]), 32'h0);
        @(negedge clk_i);

        // Same again, RF reports present
        batch(4'b0001, 4'h2, 2'b00, 2'b00, 2'b00, 2'b01);
        check("single_sync", 32'(rsp_status_o[0]), 32'h1);

        // Same id from two slots: port0 bypass, port1 ignore
        batch(4'b0110, 4'h6, 2'b00, 2'b10, 2'b01, 2'b00);
        check("pair_bypass", 32'(rsp_status_o[1]), 32'h2);
        check("pair_ignore", 32'(rsp_status_o[2]), 32'h3);

        // Backpressure on slot 0 while slot 1 keeps cycling
        rsp_ready_i[0] = 1'b0;
        @(negedge clk_i);
        req_valid_i = 4'b0001;
        req_id_i[0] = 4'h5;
        @(negedge clk_i);
        rf_present_i = 2'b01;
        req_valid_i  = 4'b0011;
        req_id_i[1]  = 4'h7;
        @(negedge clk_i);
        clr_rf();
        for (int c = 0; c < 5; c++) begin
            check("bp_valid",  32'(rsp_valid_o[0]), 32'h1);
            check("bp_status", 32'(rsp_status_o[0]), 32'h1);
            check("bp_ready",  32'(req_ready_o[0]), 32'h0);
            @(negedge clk_i);
        end
        req_valid_i    = '0;
        rsp_ready_i[0] = 1'b1;
        @(negedge clk_i);
        check("bp_release", 32'(req_ready_o[0]), 32'h1);
        repeat (3) @(negedge clk_i);

        // Id errors
        batch(4'b0100, 4'h1, 2'b01, 2'b00, 2'b00, 2'b00);
        batch(4'b1000, 4'h2, 2'b01, 2'b00, 2'b00, 2'b00);
        batch(4'b0001, 4'h3, 2'b01, 2'b00, 2'b00, 2'b00);
        check("err_three", 32'(err_cnt_o), 32'd3);
        batch(4'b0011, 4'h4, 2'b11, 2'b00, 2'b00, 2'b00);
        check("err_pair", 32'(err_cnt_o), 32'd5);
        batch(4'b0100, 4'h5, 2'b11, 2'b00, 2'b00, 2'b00);
        check("err_unused_port", 32'(err_cnt_o), 32'd6);
        for (int i = 0; i < 124; i++) batch(4'b1001, 4'h8, 2'b11, 2'b00, 2'b00, 2'b00);
        check("err_254", 32'(err_cnt_o), 32'd254);
        batch(4'b0110, 4'h8, 2'b11, 2'b00, 2'b00, 2'b00);
        check("err_sat", 32'(err_cnt_o), 32'd255);
        batch(4'b0011, 4'h8, 2'b11, 2'b00, 2'b00, 2'b00);
        check("err_sat_hold", 32'(err_cnt_o), 32'd255);

        // Asynchronous reset with slots in PEND and RESP
        rsp_ready_i = '0;
        @(negedge clk_i);
        req_valid_i = 4'hf;
        @(negedge clk_i);
        req_valid_i = '0;
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_req_ready", 32'(req_ready_o), 32'hf);
        check("arst_rsp_valid", 32'(rsp_valid_o), 32'h0);
        check("arst_rf_check",  32'(rf_check_o),  32'h0);
        check("arst_err_cnt",   32'(err_cnt_o),   32'h0);
        @(negedge clk_i);
        rst_i       = 1'b0;
        rsp_ready_i = '1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            check("post_rst_no_rsp", 32'(rsp_valid_o), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
